seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. It shares one BCD-to-segment decoder across N_DIGITS digits by sequencing the digit index, anode enables and a dead-time blanking interval. A valid/ready load port double-buffers new display values, and the buffered value is committed only at frame boundaries, which prevents tearing. It sits between the BCD counter logic, which drives its load port, and the board's segment and anode pins.

---
 rtl/seg_scan_pkg.sv | 23 ++
 rtl/bcd_seg_dec.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (common anode).
package seg_scan_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [6:0] SEG_D0 = 7'b1000000;
   localparam logic [6:0] SEG_D1 = 7'b1111001;
   localparam logic [6:0] SEG_D2 = 7'b0100100;
   localparam logic [6:0] SEG_D3 = 7'b0110000;
   localparam logic [6:0] SEG_D4 = 7'b0011001;
   localparam logic [6:0] SEG_D5 = 7'b0010010;
   localparam logic [6:0] SEG_D6 = 7'b0000010;
   localparam logic [6:0] SEG_D7 = 7'b1111000;
   localparam logic [6:0] SEG_D8 = 7'b0000000;
   localparam logic [6:0] SEG_D9 = 7'b0010000;

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank the digit.
module bcd_seg_dec
   import seg_scan_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pattern lookup, shared by every digit slot.
   always_comb begin
      seg = SEG_OFF;
      case (bcd)
         4'd0:    seg = SEG_D0;
         4'd1:    seg = SEG_D1;
         4'd2:    seg = SEG_D2;
         4'd3:    seg = SEG_D3;
         4'd4:    seg = SEG_D4;
         4'd5:    seg = SEG_D5;
         4'd6:    seg = SEG_D6;
         4'd7:    seg = SEG_D7;
         4'd8:    seg = SEG_D8;
         4'd9:    seg = SEG_D9;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display with a
// double-buffered load port that only commits new values at frame boundaries.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int BLANK_CYCLES  = 1000,
   parameter int AN_ACTIVE_LOW = 1,
   localparam int IDX_W        = $clog2(N_DIGITS),
   localparam int CNT_W        = $clog2(REFRESH_DIV)
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic                  lz_blank,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]      digit_idx
);

   localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
   localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

   scan_state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0]      slot_cnt_r;
   logic [IDX_W-1:0]      digit_idx_r;
   logic [4*N_DIGITS-1:0] active_bcd_r, pend_bcd_r;
   logic [N_DIGITS-1:0]   active_dp_r, pend_dp_r;
   logic                  pend_full_r;

   logic                  slot_end_s, blank_end_s, frame_end_s, accept_s;
   logic [3:0]            digit_s [N_DIGITS];
   logic [3:0]            cur_bcd_s;
   logic                  cur_dp_s, zero_run_s;
   logic [N_DIGITS-1:0]   lz_mask_s, sel_s, an_s;
   logic [6:0]            dec_seg_s, seg_s;
   logic                  dp_s;
   logic [6:0]            seg_r;
   logic                  dp_r;
   logic [N_DIGITS-1:0]   an_r;

   assign slot_end_s  = (slot_cnt_r == CNT_W'(REFRESH_DIV - 1));
   assign blank_end_s = (slot_cnt_r == CNT_W'(BLANK_CYCLES - 1));
   assign frame_end_s = (state_r == SHOW) && slot_end_s && (digit_idx_r == IDX_W'(N_DIGITS - 1));
   assign accept_s    = load_valid && !pend_full_r;

   assign load_ready = ~pend_full_r;
   assign seg        = seg_r;
   assign dp         = dp_r;
   assign an         = an_r;
   assign digit_idx  = digit_idx_r;

   // Next-state logic for the per-slot BLANK/SHOW sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         BLANK:   if (blank_end_s) state_nxt_s = SHOW;  else state_nxt_s = BLANK;
         SHOW:    if (slot_end_s)  state_nxt_s = BLANK; else state_nxt_s = SHOW;
         default: state_nxt_s = BLANK;
      endcase
   end

   // State register, slot counter and digit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= BLANK;
         slot_cnt_r  <= {CNT_W{1'b0}};
         digit_idx_r <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (slot_end_s) begin
            slot_cnt_r <= {CNT_W{1'b0}};
            if (digit_idx_r == IDX_W'(N_DIGITS - 1)) digit_idx_r <= {IDX_W{1'b0}};
            else                                      digit_idx_r <= digit_idx_r + IDX_W'(1);
         end else begin
            slot_cnt_r <= slot_cnt_r + CNT_W'(1);
         end
      end
   end

   // Pending/active double buffer; a commit and an accept can never coincide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_bcd_r <= {(4*N_DIGITS){1'b0}};
         active_dp_r  <= {N_DIGITS{1'b0}};
         pend_bcd_r   <= {(4*N_DIGITS){1'b0}};
         pend_dp_r    <= {N_DIGITS{1'b0}};
         pend_full_r  <= 1'b0;
      end else if (frame_end_s && pend_full_r) begin
         active_bcd_r <= pend_bcd_r;
         active_dp_r  <= pend_dp_r;
         pend_full_r  <= 1'b0;
      end else if (accept_s) begin
         pend_bcd_r   <= bcd_in;
         pend_dp_r    <= dp_in;
         pend_full_r  <= 1'b1;
      end else begin
         pend_full_r  <= pend_full_r;
      end
   end

   // Split digits, select the scanned one and build the leading-zero mask.
   always_comb begin
      for (int k = 0; k < N_DIGITS; k++) begin
         digit_s[k] = active_bcd_r[4*k +: 4];
      end
      cur_bcd_s  = digit_s[digit_idx_r];
      cur_dp_s   = active_dp_r[digit_idx_r];
      zero_run_s = 1'b1;
      lz_mask_s  = {N_DIGITS{1'b0}};
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         zero_run_s   = zero_run_s & (digit_s[k] == 4'd0);
         lz_mask_s[k] = zero_run_s;
      end
   end

   bcd_seg_dec u_dec (
      .bcd (cur_bcd_s),
      .seg (dec_seg_s)
   );

   assign sel_s = AN_ONE << digit_idx_r;

   // Next values for the pin-facing outputs.
   always_comb begin
      seg_s = SEG_OFF;
      dp_s  = 1'b1;
      an_s  = AN_OFF;
      if (state_r == SHOW) begin
         an_s = (AN_ACTIVE_LOW != 0) ? ~sel_s : sel_s;
         dp_s = ~cur_dp_s;
         if (lz_blank && lz_mask_s[digit_idx_r]) seg_s = SEG_OFF;
         else                                    seg_s = dec_seg_s;
      end else begin
         seg_s = SEG_OFF;
         dp_s  = 1'b1;
         an_s  = AN_OFF;
      end
   end

   // Output registers, one cycle behind state and digit index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_r <= SEG_OFF;
         dp_r  <= 1'b1;
         an_r  <= AN_OFF;
      end else begin
         seg_r <= seg_s;
         dp_r  <= dp_s;
         an_r  <= an_s;
      end
   end

endmodule
